// File: rtl/param_digital_lock.sv
// param_digital_lock: debounced keypad lock with attempt counting, timed lockout,
// auto-relock and in-field code reprogramming.
module param_digital_lock #(
    parameter int N_BTN           = 4,
    parameter int CODE_LEN        = 4,
    parameter logic [CODE_LEN*$clog2(N_BTN)-1:0] DEFAULT_CODE = 8'hE4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MAX_TRIES       = 3,
    parameter int LOCKOUT_CYCLES  = 50000,
    parameter int OPEN_CYCLES     = 100000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_BTN-1:0]               button,
    input  logic                           relock,
    input  logic                           prog_en,
    output logic                           unlocked,
    output logic                           lockout,
    output logic                           err,
    output logic                           press,
    output logic [CODE_LEN-1:0]            progress,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);
    localparam int DW   = $clog2(N_BTN);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int IW   = $clog2(CODE_LEN + 1);
    localparam int TW   = $clog2(MAX_TRIES + 1);
    localparam int TMAX = LOCKOUT_CYCLES > OPEN_CYCLES ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int MW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {ENTRY, CHECK, OPEN, PROG, LOCKOUT} state_t;

    logic                   held_q, held_d;
    logic [N_BTN-1:0]       pat_q;
    logic [CW-1:0]          cnt_q, cnt_d, run_w;
    logic                   onehot_w, accept_w;
    logic [DW-1:0]          dig_w;
    state_t                 state_q, state_d;
    logic [CODE_LEN*DW-1:0] code_q, code_d, entry_q, entry_d, shadow_q, shadow_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          tries_q, tries_d;
    logic [MW-1:0]          timer_q, timer_d;
    logic                   err_d, press_d;
    logic [CODE_LEN-1:0]    progress_d;

    assign tries_left = tries_q;

    // run_w is the length of the current run of identical samples, saturating one past the target
    always_comb begin
        run_w    = (button == pat_q) ? cnt_q + CW'(1) : CW'(1);
        cnt_d    = (run_w > CW'(DEBOUNCE_CYCLES)) ? CW'(DEBOUNCE_CYCLES) : run_w;
        onehot_w = (button != '0) && ((button & (button - N_BTN'(1))) == '0);
        accept_w = !held_q && onehot_w && run_w == CW'(DEBOUNCE_CYCLES);
        held_d   = accept_w ? 1'b1 :
                   (held_q && button == '0 && run_w == CW'(DEBOUNCE_CYCLES)) ? 1'b0 : held_q;
        dig_w    = '0;
        for (int i = 0; i < N_BTN; i++)
            if (button[i]) dig_w = DW'(i);
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        entry_d    = entry_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        tries_d    = tries_q;
        timer_d    = timer_q + MW'(1);
        err_d      = 1'b0;
        press_d    = 1'b0;
        progress_d = '0;
        case (state_q)
            ENTRY: begin
                if (idx_q == IW'(CODE_LEN)) state_d = CHECK;
                else if (accept_w) begin
                    entry_d[idx_q*DW +: DW] = dig_w;
                    idx_d   = idx_q + IW'(1);
                    press_d = 1'b1;
                end
            end
            CHECK: begin
                idx_d   = '0;
                timer_d = '0;
                if (entry_q == code_q) begin
                    state_d = OPEN;
                    tries_d = TW'(MAX_TRIES);
                end else begin
                    err_d   = 1'b1;
                    tries_d = tries_q - TW'(1);
                    state_d = (tries_q == TW'(1)) ? LOCKOUT : ENTRY;
                end
            end
            LOCKOUT: begin
                if (timer_q == MW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = ENTRY;
                    tries_d = TW'(MAX_TRIES);
                end
            end
            OPEN: begin
                if (relock || (OPEN_CYCLES != 0 && timer_q == MW'(OPEN_CYCLES - 1))) state_d = ENTRY;
                else if (prog_en) state_d = PROG;
            end
            PROG: begin
                // a full shadow commits even if prog_en falls in the same cycle
                if (idx_q == IW'(CODE_LEN)) begin
                    code_d  = shadow_q;
                    idx_d   = '0;
                    state_d = ENTRY;
                end else if (!prog_en) begin
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = OPEN;
                end else if (accept_w) begin
                    shadow_d[idx_q*DW +: DW] = dig_w;
                    idx_d   = idx_q + IW'(1);
                    press_d = 1'b1;
                end
            end
            default: state_d = ENTRY;
        endcase
        for (int i = 0; i < CODE_LEN; i++)
            progress_d[i] = (state_d == ENTRY || state_d == PROG) && idx_d > IW'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q   <= 1'b0;
            pat_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ENTRY;
            code_q   <= DEFAULT_CODE;
            entry_q  <= '0;
            shadow_q <= '0;
            idx_q    <= '0;
            tries_q  <= TW'(MAX_TRIES);
            timer_q  <= '0;
            unlocked <= 1'b0;
            lockout  <= 1'b0;
            err      <= 1'b0;
            press    <= 1'b0;
            progress <= '0;
        end else begin
            held_q   <= held_d;
            pat_q    <= button;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            code_q   <= code_d;
            entry_q  <= entry_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            tries_q  <= tries_d;
            timer_q  <= timer_d;
            unlocked <= state_d == OPEN || state_d == PROG;
            lockout  <= state_d == LOCKOUT;
            err      <= err_d;
            press    <= press_d;
            progress <= progress_d;
        end
    end
endmodule

// File: tb/tb_param_digital_lock.sv
// tb_param_digital_lock: random keypad traffic against a code-level lock model;
// expected events are queued at stimulus time and matched by an output monitor.
module tb_param_digital_lock;
    localparam int CL = 4, MAXT = 3, LOCKC = 20, OPENC = 30;
    localparam logic [7:0] DEF = 8'hE4;
    localparam int M_ENTRY = 0, M_OPEN = 1, M_PROG = 2, M_LOCK = 3;

    logic       clk = 1'b0, rst = 1'b1, relock = 1'b0, prog_en = 1'b0;
    logic [3:0] button = '0;
    logic       unlocked, lockout, err, press;
    logic [3:0] progress;
    logic [1:0] tries_left;

    param_digital_lock #(.DEBOUNCE_CYCLES(2), .LOCKOUT_CYCLES(LOCKC), .OPEN_CYCLES(OPENC)) dut (
        .clk(clk), .rst(rst), .button(button), .relock(relock), .prog_en(prog_en),
        .unlocked(unlocked), .lockout(lockout), .err(err), .press(press),
        .progress(progress), .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    typedef enum int {K_PRESS, K_ERR, K_LOCK, K_LOCKEND, K_OPEN, K_CLOSE} kind_t;
    typedef struct {kind_t kind; int val; int dur;} ev_t;
    ev_t exp_q[$];
    int  checks = 0, errors = 0;
    bit  done = 1'b0;
    int  mcode[CL];
    int  mbuf[$];
    int  mode, mtries;

    function automatic void push(kind_t k, int v, int d);
        ev_t e;
        e.kind = k; e.val = v; e.dur = d;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CL; i++) mcode[i] = int'((DEF >> (2*i)) & 8'd3);
        mbuf.delete();
        mode = M_ENTRY;
        mtries = MAXT;
    endfunction

    function automatic logic [7:0] model_code();
        logic [7:0] r;
        for (int i = 0; i < CL; i++) r[2*i +: 2] = 2'(mcode[i]);
        return r;
    endfunction

    // Code-level lock behaviour: digits collect into a buffer, a full buffer is judged at once.
    function automatic void model_press(int d);
        bit ok;
        if (mode != M_ENTRY && mode != M_PROG) return;
        mbuf.push_back(d);
        push(K_PRESS, (1 << mbuf.size()) - 1, -1);
        if (mbuf.size() != CL) return;
        if (mode == M_PROG) begin
            for (int i = 0; i < CL; i++) mcode[i] = mbuf[i];
            push(K_CLOSE, 0, -1);
            mode = M_ENTRY;
        end else begin
            ok = 1'b1;
            for (int i = 0; i < CL; i++) if (mbuf[i] != mcode[i]) ok = 1'b0;
            if (ok) begin
                mtries = MAXT;
                push(K_OPEN, MAXT, 2);
                mode = M_OPEN;
            end else begin
                mtries--;
                push(K_ERR, mtries, -1);
                if (mtries == 0) begin
                    push(K_LOCK, 0, -1);
                    push(K_LOCKEND, MAXT, LOCKC);
                    mode = M_LOCK;
                end
            end
        end
        mbuf.delete();
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(int d);
        int h, g;
        h = $urandom_range(4, 2);
        g = $urandom_range(4, 2);
        button = 4'(1 << d);
        model_press(d);
        tick(h);
        button = '0;
        tick(g);
    endtask

    task automatic enter_code(logic [7:0] c);
        for (int i = 0; i < CL; i++) press_btn(int'(c[2*i +: 2]));
    endtask

    task automatic do_relock();
        relock = 1'b1;
        if (mode == M_OPEN) begin
            push(K_CLOSE, 0, -1);
            mode = M_ENTRY;
        end
        tick(1);
        relock = 1'b0;
        tick(1);
    endtask

    task automatic prog_start();
        prog_en = 1'b1;
        mode = M_PROG;
        mbuf.delete();
        tick(1);
    endtask

    task automatic prog_drop();
        prog_en = 1'b0;
        if (mode == M_PROG) begin
            mode = M_OPEN;
            mbuf.delete();
        end
        tick(1);
    endtask

    task automatic wait_lock();
        tick(LOCKC + 1);
        mode = M_ENTRY;
        mtries = MAXT;
    endtask

    task automatic expect_ev(kind_t k, int v, int d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got val=%0d dur=%0d, expected no event", k.name(), v, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || (e.dur >= 0 && e.dur != d)) begin
                errors++;
                $display("FAIL event_%s: got %s val=%0d dur=%0d, expected %s val=%0d dur=%0d",
                         k.name(), k.name(), v, d, e.kind.name(), e.val, e.dur);
            end
        end
    endtask

    task automatic chk(string n, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, got, want);
        end
    endtask

    initial begin
        int cyc, last_press, lock_start, open_start;
        bit pu, pl;
        cyc = 0; last_press = 0; lock_start = 0; open_start = 0;
        repeat (4) @(negedge clk);
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_press", int'(press), 0);
        chk("rst_progress", int'(progress), 0);
        chk("rst_tries_left", int'(tries_left), MAXT);
        pu = unlocked;
        pl = lockout;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (press) begin
                last_press = cyc;
                expect_ev(K_PRESS, int'(progress), 0);
            end
            if (err) expect_ev(K_ERR, int'(tries_left), 0);
            if (lockout && !pl) begin
                lock_start = cyc;
                expect_ev(K_LOCK, int'(tries_left), 0);
            end
            if (!lockout && pl) expect_ev(K_LOCKEND, int'(tries_left), cyc - lock_start);
            if (unlocked && !pu) begin
                open_start = cyc;
                expect_ev(K_OPEN, int'(tries_left), cyc - last_press);
            end
            if (!unlocked && pu) expect_ev(K_CLOSE, int'(progress), cyc - open_start);
            pu = unlocked;
            pl = lockout;
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] c;
        logic [3:0] multi [6];
        multi = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1100, 4'b1111};
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(2);
        enter_code(DEF);
        do_relock();
        repeat (3) enter_code(8'hFF);
        press_btn(0);
        press_btn(1);
        wait_lock();
        button = 4'b0010; tick(1);
        button = 4'b0011; tick(10);
        button = '0; tick(3);
        repeat (6) begin
            button = ($urandom_range(1, 0) != 0) ? multi[$urandom_range(5, 0)] : 4'(1 << $urandom_range(3, 0));
            tick((button == 4'b0001 || button == 4'b0010 || button == 4'b0100 || button == 4'b1000) ? 1 : $urandom_range(6, 1));
            button = '0;
            tick(3);
        end
        enter_code(DEF);
        prog_start();
        enter_code(8'h1B);
        prog_drop();
        enter_code(DEF);
        enter_code(8'h1B);
        do_relock();
        enter_code(8'h1B);
        prog_start();
        press_btn(2);
        press_btn(0);
        prog_drop();
        do_relock();
        enter_code(8'h1B);
        do_relock();
        enter_code(8'h1B);
        push(K_CLOSE, 0, OPENC);
        mode = M_ENTRY;
        tick(OPENC + 2);
        enter_code(8'h1B);
        relock = 1'b1;
        prog_en = 1'b1;
        push(K_CLOSE, 0, -1);
        mode = M_ENTRY;
        tick(1);
        relock = 1'b0;
        prog_en = 1'b0;
        tick(2);
        repeat (10) begin
            c = ($urandom_range(1, 0) != 0) ? model_code() : 8'($urandom);
            enter_code(c);
            if (mode == M_OPEN) do_relock();
            else if (mode == M_LOCK) wait_lock();
        end
        enter_code(model_code());
        prog_start();
        press_btn(1);
        press_btn(3);
        rst = 1'b1;
        prog_en = 1'b0;
        push(K_CLOSE, 0, -1);
        model_reset();
        tick(2);
        rst = 1'b0;
        tick(2);
        enter_code(DEF);
        do_relock();
        tick(5);
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end
endmodule
